// File: rtl/qvga_frame_reader.sv
// QVGA frame-buffer reader: 640x480@60 VGA timing, 2x2 upscaled fetch, 3-cycle aligned outputs.
// Optional colour-bar generator enabled by defining QVGA_FRAME_READER_PATTERN_EN.
module qvga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef QVGA_FRAME_READER_PATTERN_EN
  input  logic        pattern_en,
`endif
  output logic [16:0] rAddr,
  output logic        oe,
  input  logic [11:0] rData,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Timing qualifiers travelling alongside the fetched pixel.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic [9:0]  h_cnt, v_cnt;
  stage_t      s0, s1, s2;
  logic [16:0] addr0;
  logic        fetch0;
  logic [11:0] pix2;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign s0.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign s0.hs  = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign s0.vs  = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
  assign s0.fs  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // (v/2)*320 + h/2 as (v/2)<<8 + (v/2)<<6 + h/2.
  assign addr0 = {v_cnt[9:1], 8'b0} + {2'b0, v_cnt[9:1], 6'b0} + {8'b0, h_cnt[9:1]};

`ifdef QVGA_FRAME_READER_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar0, bar1, bar2;
  logic       pat1, pat2;

  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    bar0 = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= 10'(i * BAR_W)) bar0 = 3'(i);
    end
  end

  assign fetch0 = s0.act && !pattern_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar1 <= '0;
      bar2 <= '0;
      pat1 <= 1'b0;
      pat2 <= 1'b0;
    end else begin
      bar1 <= bar0;
      bar2 <= bar1;
      pat1 <= pattern_en;
      pat2 <= pat1;
    end
  end

  // Bar index bits map to absent colour channels: bit1->R, bit2->G, bit0->B.
  assign pix2 = pat2 ? {{4{~bar2[1]}}, {4{~bar2[2]}}, {4{~bar2[0]}}} : rData;
`else
  assign fetch0 = s0.act;
  assign pix2   = rData;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= STAGE_IDLE;
      s2    <= STAGE_IDLE;
      oe    <= 1'b0;
      rAddr <= '0;
    end else begin
      s1    <= s0;
      s2    <= s1;
      oe    <= fetch0;
      rAddr <= fetch0 ? addr0 : '0;
    end
  end

  // rData for the stage-1 address is valid while s2 holds the matching qualifiers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      h_sync      <= s2.hs;
      v_sync      <= s2.vs;
      de          <= s2.act;
      frame_start <= s2.fs;
      {red, green, blue} <= s2.act ? pix2 : 12'h000;
    end
  end

endmodule
